// File: rtl/extmem_req_arbiter.sv
// Two-client round-robin request arbiter in front of the external-memory SRAM wrapper.
// It registers one granted request at a time and holds its fields on the wrapper bus
// until the wrapper responds. It then routes the response back to the owning client.
// A watchdog aborts any request whose response never arrives.
module extmem_req_arbiter #(
  parameter int ADDR_W         = 40,
  parameter int DATA_W         = 64,
  parameter int TIMEOUT_CYCLES = 16   // legal range 2..255
) (
  input  logic              clk,
  input  logic              reset,            // synchronous, active-low

  input  logic              c0_req_valid_i,
  output logic              c0_req_ready_o,
  input  logic [ADDR_W-1:0] c0_req_addr_i,
  input  logic [4:0]        c0_req_cmd_i,
  input  logic [2:0]        c0_req_typ_i,
  input  logic [DATA_W-1:0] c0_req_data_i,
  output logic              c0_resp_valid_o,
  output logic              c0_resp_err_o,
  output logic [DATA_W-1:0] c0_resp_data_o,

  input  logic              c1_req_valid_i,
  output logic              c1_req_ready_o,
  input  logic [ADDR_W-1:0] c1_req_addr_i,
  input  logic [4:0]        c1_req_cmd_i,
  input  logic [2:0]        c1_req_typ_i,
  input  logic [DATA_W-1:0] c1_req_data_i,
  output logic              c1_resp_valid_o,
  output logic              c1_resp_err_o,
  output logic [DATA_W-1:0] c1_resp_data_o,

  input  logic              mem_req_ready_i,
  output logic              mem_req_valid_o,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  output logic [4:0]        mem_req_cmd_o,
  output logic [2:0]        mem_req_typ_o,
  output logic [DATA_W-1:0] mem_req_data_o,
  input  logic              mem_resp_valid_i,
  input  logic [DATA_W-1:0] mem_resp_data_i,

  output logic              err_timeout_o
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [4:0]        cmd;
    logic [2:0]        typ;
    logic [DATA_W-1:0] data;
  } req_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e     state_q, state_d;
  req_t       hold_q, hold_d;
  logic       owner_q, owner_d;
  logic       last_grant_q, last_grant_d;
  logic [7:0] cnt_q, cnt_d;
  logic       err_timeout_q, err_timeout_d;

  // Combinational helpers shared by the output and next-state logic.
  logic run;
  logic grant;
  logic handshake;
  logic resp_hit;
  logic abort;
  logic deliver;
  req_t req_in;

  // The block is held quiet while reset is asserted.
  assign run = reset;

  // On a tie the client that did not win last time gets the grant; otherwise the sole requester wins.
  assign grant = (c0_req_valid_i && c1_req_valid_i) ? ~last_grant_q : c1_req_valid_i;

  assign c0_req_ready_o = run && (state_q == S_IDLE) && c0_req_valid_i && !grant;
  assign c1_req_ready_o = run && (state_q == S_IDLE) && c1_req_valid_i &&  grant;
  assign handshake      = c0_req_ready_o || c1_req_ready_o;

  assign req_in = grant ? '{addr: c1_req_addr_i, cmd: c1_req_cmd_i, typ: c1_req_typ_i, data: c1_req_data_i}
                        : '{addr: c0_req_addr_i, cmd: c0_req_cmd_i, typ: c0_req_typ_i, data: c0_req_data_i};

  // The watchdog fires in the TIMEOUT_CYCLES-th waiting cycle if no response has arrived by then.
  assign resp_hit = run && (state_q == S_WAIT_RESP) && mem_resp_valid_i;
  assign abort    = run && (state_q == S_WAIT_RESP) && !mem_resp_valid_i && (cnt_q == CNT_LAST);
  assign deliver  = resp_hit || abort;

  assign c0_resp_valid_o = deliver && !owner_q;
  assign c1_resp_valid_o = deliver &&  owner_q;
  assign c0_resp_err_o   = abort   && !owner_q;
  assign c1_resp_err_o   = abort   &&  owner_q;
  assign c0_resp_data_o  = (run && !abort) ? mem_resp_data_i : '0;
  assign c1_resp_data_o  = (run && !abort) ? mem_resp_data_i : '0;

  // The wrapper re-reads these fields while it builds the response, so they come straight from the holding register.
  assign mem_req_valid_o = run && (state_q == S_ISSUE);
  assign mem_req_addr_o  = hold_q.addr;
  assign mem_req_cmd_o   = hold_q.cmd;
  assign mem_req_typ_o   = hold_q.typ;
  assign mem_req_data_o  = hold_q.data;
  assign err_timeout_o   = err_timeout_q;

  // Next-state logic: grant capture in IDLE, wrapper handshake in ISSUE, response or timeout in WAIT_RESP.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d       = state_q;
    hold_d        = hold_q;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    cnt_d         = cnt_q;
    err_timeout_d = err_timeout_q;

    unique case (state_q)
      S_IDLE: begin
        if (handshake) begin
          hold_d       = req_in;
          owner_d      = grant;
          last_grant_d = grant;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (mem_req_ready_i) begin
          cnt_d   = '0;
          state_d = S_WAIT_RESP;
        end
      end
      S_WAIT_RESP: begin
        if (mem_resp_valid_i) begin
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err_timeout_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and holding registers, with a synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so only the clock edge is in the sensitivity list.
    if (!reset) begin
      state_q       <= S_IDLE;
      hold_q        <= '0;
      owner_q       <= 1'b0;
      last_grant_q  <= 1'b1;
      cnt_q         <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      hold_q        <= hold_d;
      owner_q       <= owner_d;
      last_grant_q  <= last_grant_d;
      cnt_q         <= cnt_d;
      err_timeout_q <= err_timeout_d;
    end
  end

endmodule

// File: doc/extmem_req_arbiter.md
Name: extmem_req_arbiter

Overview:
- Two-client round-robin front end sitting directly upstream of the external-memory SRAM wrapper.
- Accepts load/store requests from two RoCC-side clients: client 0 (accelerator load port) and client 1 (accelerator store port).
- Registers the granted request and presents it on the wrapper's request bus.
- Holds the request fields stable until the wrapper's response arrives, because the wrapper re-reads the request bus while it builds the response.
- Routes the response back to the owning client; a watchdog flags responses that never arrive.

Parameters:
- ADDR_W, 40, request/response address width.
- DATA_W, 64, request/response data width.
- TIMEOUT_CYCLES, 16, cycles in WAIT_RESP without a response before the request is aborted; legal range 2..255.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-low reset
- cN_req_valid_i  input  1  client N request valid (N=0,1)
- cN_req_ready_o  output  1  client N request ready
- cN_req_addr_i  input  ADDR_W  client N byte address
- cN_req_cmd_i  input  5  client N command (0=read, 1=write)
- cN_req_typ_i  input  3  client N size code
- cN_req_data_i  input  DATA_W  client N write data
- cN_resp_valid_o  output  1  client N response pulse (no backpressure)
- cN_resp_err_o  output  1  qualifies cN_resp_valid_o: timeout abort
- cN_resp_data_o  output  DATA_W  client N response data
- mem_req_ready_i  input  1  wrapper ready
- mem_req_valid_o  output  1  wrapper request valid
- mem_req_addr_o / cmd_o / typ_o / data_o  output  ADDR_W/5/3/DATA_W  held request fields
- mem_resp_valid_i  input  1  wrapper response valid
- mem_resp_data_i  input  DATA_W  wrapper response data
- err_timeout_o  output  1  sticky timeout flag

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE, holding register cleared, owner=0, last_grant=1 (client 0 wins the first tie), timeout counter=0, err_timeout_o=0.
  - All valid/ready outputs 0 while reset is asserted. A reset mid-transaction discards the held request; no response is delivered.
- Outputs outside reset:
  - mem_req_*_o always drive the holding register (0 after reset).
  - cN_resp_data_o = mem_resp_data_i, or 0 on an abort.
- States: IDLE, ISSUE, WAIT_RESP.
- IDLE:
  - grant = sole requester; if both request, grant = !last_grant.
  - cN_req_ready_o = (state==IDLE) & grant==N. Combinational from valid inputs; no ready without a valid.
  - On client handshake: capture addr/cmd/typ/data, owner=N, last_grant=N, go to ISSUE.
  - mem_req_valid_o is asserted the next cycle, giving one cycle of latency.
- ISSUE:
  - mem_req_valid_o=1.
  - On mem_req_ready_i: go to WAIT_RESP and clear the counter.
  - mem_req_valid_o drops the cycle after acceptance, so the wrapper never sees a second handshake for the same request.
- WAIT_RESP:
  - mem_req_valid_o=0; holding-register fields stay unchanged through and including the response cycle.
  - On mem_resp_valid_i: c[owner]_resp_valid_o=1 that same cycle (combinational pass-through), err=0, go to IDLE.
  - Otherwise the counter increments. When the counter reaches TIMEOUT_CYCLES-1 without a response:
    - c[owner]_resp_valid_o=1 and c[owner]_resp_err_o=1, with data 0.
    - err_timeout_o is set and stays set until reset.
    - Go to IDLE.
  - A late response arriving in IDLE or ISSUE is dropped silently.
- Non-owner cN_resp_valid_o is always 0.
- No new client request is accepted until the state has returned to IDLE, so at most one request is outstanding.
- A response and a new client request can never coincide: ready is only asserted in IDLE.
- cmd/typ are passed through unchecked; the wrapper owns size masking.
- Round-robin pointer updates only on a client handshake.

Test Plan:
- Single read, client 0, addr 0x40, cmd 0, typ 0, wrapper returns 0xDEADBEEF_CAFEF00D two cycles after its handshake → mem_req_valid_o high for exactly 1 cycle; addr 0x40 held through the response cycle; c0_resp_valid_o pulses once with that data; c1_resp_valid_o stays 0.
- Both clients valid every cycle from reset, 4 transactions → grant order 0,1,0,1; each client receives exactly 2 responses, each routed to the correct owner.
- Wrapper holds mem_req_ready_i=0 for 3 cycles → mem_req_valid_o stays high, fields stay constant, and no handshake reaches either client (both cN_req_ready_o stay 0) for 4 cycles.
- No response with TIMEOUT_CYCLES=16 → 16 cycles after acceptance, the owner sees resp_valid=1, err=1, data 0; err_timeout_o=1 and stays 1; the next request completes normally.
- reset=0 asserted in WAIT_RESP, then a response arrives → no client resp_valid; all outputs 0; client 0 wins the first grant after reset.
- Write from client 1: addr 0x88, cmd 1, typ 4, data 0x1122334455667788 → the wrapper sees identical fields; c1_resp_valid_o pulses once; holding fields are unchanged until the response cycle.
